seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the board's 7-segment display drivers. It samples an active-low, multiplexed SEG/AN display bus, either from pins via Pmod loopback or from an internal driver instance, and waits for each enabled digit to settle. It then decodes each segment pattern back to a BCD value and publishes a coherent 4-digit frame. It is used for on-board self-test and as the scoreboard front end in driver testbenches.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on SEG_IN/AN_IN; minimum 2.
- SETTLE_CYCLES, 16: consecutive cycles that AN and SEG must hold steady before a capture; minimum 1.
- TIMEOUT_CYCLES, 2_000_000: cycles without a completed frame before a partial frame is forced (20 ms at 100 MHz).

Ports:
- CLK, input, 1: 100 MHz clock. One clock domain; reset is synchronous and active-high.
- RST, input, 1: synchronous, active-high reset.
- SEG_IN, input, 7: active-low segments. Bit 0 = a … bit 6 = g.
- AN_IN, input, 4: active-low digit enables. Bit 0 = rightmost digit.
- DIGITS, output, 16: BCD per digit. Nibble i = digit i.
- VALID, output, 4: digit i was captured with a legal 0–9 pattern in this frame.
- ERR, output, 4: digit i was captured with a pattern that is neither legal nor blank.
- FRAME_DONE, output, 1: one-cycle pulse. DIGITS/VALID/ERR were updated this cycle.

## Operation
- **Synchronizer:** SEG_IN and AN_IN each pass through SYNC_STAGES flops. All logic below uses the synchronized values (s_seg, s_an).
- **FSM states:** IDLE, SETTLE, HOLD.
  - IDLE → SETTLE when s_an has exactly one bit low. The current s_an and s_seg are latched and the settle counter is cleared.
  - SETTLE: the counter increments each cycle while s_an and s_seg equal the latched values.
    - Any change with s_an still one-hot restarts SETTLE with the new values.
    - s_an not one-hot → IDLE.
    - When the counter reaches SETTLE_CYCLES−1, capture and go to HOLD.
  - HOLD: no further capture until s_an changes. Then → SETTLE if the new s_an is one-hot, otherwise → IDLE. A SEG change while AN is static in HOLD is ignored.
- **Decode** (active-low patterns):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - 1111111 = blank.
  - Anything else = error.
- **Capture into working buffer, digit i:**
  - Legal pattern: nib[i] = value, v[i] = 1, e[i] = 0.
  - Blank: nib[i] = 0, v = 0, e = 0.
  - Error: nib[i] = 0, v = 0, e = 1.
  - seen[i] is set in all three cases. A repeat capture of the same digit overwrites the earlier one.
- **Frame publish:** occurs when seen == 4'b1111, or when the timeout counter reaches TIMEOUT_CYCLES−1 with seen ≠ 0.
  - The working buffer is copied to DIGITS/VALID/ERR.
  - Unseen digits publish as 0/0/0.
  - FRAME_DONE pulses, and seen, the working buffer and the timeout counter clear.
- **Timeout with seen == 0:** the counter wraps to 0 and nothing is published. This is the static-AN case with the display fully off.
- **Same-cycle capture and timeout:** the capture is included in the published frame.
- **Published outputs** are stable between FRAME_DONE pulses.

## Timing
- **Reset values:** DIGITS = 16'h0000, VALID = 4'b0000, ERR = 4'b0000, FRAME_DONE = 0. FSM = IDLE; seen, buffers and counters = 0. The synchronizer flops reset to all-ones (idle bus).
- **Reset mid-frame:** the partial frame is discarded and no FRAME_DONE is issued.
- **Pin-to-capture latency:** SYNC_STAGES + SETTLE_CYCLES + 1 cycles after AN/SEG become stable on the pins, counting the cycle that enters SETTLE.
- **FRAME_DONE:** asserted in the cycle after the capture that completes seen, registered together with DIGITS/VALID/ERR.
- **Widths:**
  - Settle counter: $clog2(SETTLE_CYCLES) + 1 bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES) bits.
  - Neither counter may overflow before its compare value.

## Structure
- **Package seg7_pkg** holds:
  - the ten digit patterns and the blank pattern, as 7-bit active-low localparams;
  - NUM_DIGITS = 4;
  - the decode status enum (LEGAL, BLANK, ILLEGAL).
- **Sub-module seg7_pattern_decode:** combinational. Takes a 7-bit pattern and returns the 4-bit value and the 2-bit status. It is shared with future driver checkers.

## Test plan
- **Static single digit:** drive AN_IN = 1110, SEG_IN = 0010010 (5) constantly. After TIMEOUT_CYCLES, expect FRAME_DONE with DIGITS[3:0] = 5, VALID = 0001, ERR = 0000.
- **Full scan:** cycle AN through 1110/1101/1011/0111 at 1000 cycles per digit with digits 4, 3, 2, 1. Expect FRAME_DONE after the fourth capture with DIGITS = 16'h1234, VALID = 1111.
- **Ghosting:** change SEG 3 cycles after each AN switch (SETTLE_CYCLES = 16). The captured value must be the post-change pattern, not the pre-change one.
- **Illegal and blank:** digit 2 = 0101010 and digit 3 = 1111111, with digits 0 and 1 = 7. Expect VALID = 0011, ERR = 0100, DIGITS = 16'h0077.
- **Bad AN:** AN_IN = 1100 or 1111 held for 100 cycles. Expect no capture and no FRAME_DONE.
- **Reset mid-frame:** after two of four digits are captured, assert RST for 1 cycle. Outputs must be 0, and the next frame must contain only post-reset captures.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path: active-low digit
// patterns, digit count, decode status and scan FSM states.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low patterns, bit 6 = g ... bit 0 = a
  localparam logic [6:0] PAT_0     = 7'b1000000;
  localparam logic [6:0] PAT_1     = 7'b1111001;
  localparam logic [6:0] PAT_2     = 7'b0100100;
  localparam logic [6:0] PAT_3     = 7'b0110000;
  localparam logic [6:0] PAT_4     = 7'b0011001;
  localparam logic [6:0] PAT_5     = 7'b0010010;
  localparam logic [6:0] PAT_6     = 7'b0000010;
  localparam logic [6:0] PAT_7     = 7'b1111000;
  localparam logic [6:0] PAT_8     = 7'b0000000;
  localparam logic [6:0] PAT_9     = 7'b0010000;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  typedef enum logic [1:0] {LEGAL, BLANK, ILLEGAL} seg_status_e;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to BCD decoder.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] val_o,
  output logic [1:0] status_o
);

  // Table lookup; anything that is not a digit or blank is flagged illegal
  always_comb begin
    val_o    = 4'd0;
    status_o = LEGAL;
    unique case (pat_i)
      PAT_0:     val_o = 4'd0;
      PAT_1:     val_o = 4'd1;
      PAT_2:     val_o = 4'd2;
      PAT_3:     val_o = 4'd3;
      PAT_4:     val_o = 4'd4;
      PAT_5:     val_o = 4'd5;
      PAT_6:     val_o = 4'd6;
      PAT_7:     val_o = 4'd7;
      PAT_8:     val_o = 4'd8;
      PAT_9:     val_o = 4'd9;
      PAT_BLANK: status_o = BLANK;
      default:   status_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low SEG/AN bus, waits for each enabled digit
// to settle, decodes it and publishes coherent 4-digit frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SEG_IN,
  input  logic [3:0]  AN_IN,
  output logic [15:0] DIGITS,
  output logic [3:0]  VALID,
  output logic [3:0]  ERR,
  output logic        FRAME_DONE
);

  localparam int SCW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TOW-1:0] TMO_LAST    = TOW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][6:0] seg_sync_q;
  logic [SYNC_STAGES-1:0][3:0] an_sync_q;
  logic [6:0]     s_seg;
  logic [3:0]     s_an;
  logic           an_onehot;

  scan_state_e    state_q;
  logic [3:0]     lat_an_q;
  logic [6:0]     lat_seg_q;
  logic [SCW-1:0] cnt_q;
  logic           steady;
  logic           cap;

  logic [3:0]     dec_val;
  logic [1:0]     dec_status;

  logic [NUM_DIGITS-1:0][3:0] nib_q, nib_d;
  logic [NUM_DIGITS-1:0]      v_q, v_d, e_q, e_d, seen_q, seen_d;
  logic [TOW-1:0]             tmo_q;
  logic                       tmo_hit;
  logic                       publish;

  logic [15:0] digits_q;
  logic [3:0]  valid_q, err_q;
  logic        done_q;

  // Input synchronizers, reset to the idle (all-off) bus level
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_sync_q <= '1;
      an_sync_q  <= '1;
    end else begin
      seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], SEG_IN};
      an_sync_q  <= {an_sync_q[SYNC_STAGES-2:0], AN_IN};
    end
  end

  assign s_seg     = seg_sync_q[SYNC_STAGES-1];
  assign s_an      = an_sync_q[SYNC_STAGES-1];
  assign an_onehot = $onehot(~s_an);
  assign steady    = (s_an == lat_an_q) && (s_seg == lat_seg_q);
  // Capture fires on the last settle cycle; the FSM moves to HOLD on the same edge
  assign cap       = (state_q == SETTLE) && an_onehot && steady && (cnt_q == SETTLE_LAST);

  // Scan FSM: wait for a one-hot AN with stable SEG, capture once, hold until AN moves
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      lat_an_q  <= '1;
      lat_seg_q <= '1;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (an_onehot) begin
          state_q   <= SETTLE;
          lat_an_q  <= s_an;
          lat_seg_q <= s_seg;
          cnt_q     <= '0;
        end
        SETTLE: begin
          if (!an_onehot) begin
            state_q <= IDLE;
          end else if (!steady) begin
            lat_an_q  <= s_an;
            lat_seg_q <= s_seg;
            cnt_q     <= '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: if (s_an != lat_an_q) begin
          if (an_onehot) begin
            state_q   <= SETTLE;
            lat_an_q  <= s_an;
            lat_seg_q <= s_seg;
            cnt_q     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  seg7_pattern_decode u_dec (
    .pat_i    (lat_seg_q),
    .val_o    (dec_val),
    .status_o (dec_status)
  );

  // Merge this cycle's capture into the working buffer before deciding to publish,
  // so a capture coinciding with the timeout lands in the forced frame
  always_comb begin
    nib_d  = nib_q;
    v_d    = v_q;
    e_d    = e_q;
    seen_d = seen_q;
    if (cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!lat_an_q[i]) begin
          nib_d[i]  = (dec_status == LEGAL) ? dec_val : 4'd0;
          v_d[i]    = (dec_status == LEGAL);
          e_d[i]    = (dec_status == ILLEGAL);
          seen_d[i] = 1'b1;
        end
      end
    end
  end

  assign tmo_hit = (tmo_q == TMO_LAST);
  assign publish = (&seen_d) || (tmo_hit && (|seen_d));

  // Working buffer, timeout counter and registered frame outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      nib_q    <= '0;
      v_q      <= '0;
      e_q      <= '0;
      seen_q   <= '0;
      tmo_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
    end else if (publish) begin
      digits_q <= nib_d;
      valid_q  <= v_d;
      err_q    <= e_d;
      done_q   <= 1'b1;
      nib_q    <= '0;
      v_q      <= '0;
      e_q      <= '0;
      seen_q   <= '0;
      tmo_q    <= '0;
    end else begin
      nib_q  <= nib_d;
      v_q    <= v_d;
      e_q    <= e_d;
      seen_q <= seen_d;
      done_q <= 1'b0;
      tmo_q  <= tmo_hit ? '0 : tmo_q + 1'b1;
    end
  end

  assign DIGITS     = digits_q;
  assign VALID      = valid_q;
  assign ERR        = err_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued as the
// scan stimulus is driven and popped on every FRAME_DONE.
module tb_seg7_scan_decoder;

  localparam int SYNC   = 2;
  localparam int SETTLE = 16;
  localparam int TMO    = 10000;
  localparam int DWELL  = 1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  SEG_IN;
  logic [3:0]  AN_IN;
  logic [15:0] DIGITS;
  logic [3:0]  VALID;
  logic [3:0]  ERR;
  logic        FRAME_DONE;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
  } frame_t;

  frame_t sb[$];
  frame_t f;

  logic [6:0] pats[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int n_chk = 0;
  int n_err = 0;
  int nframes = 0;
  int cyc = 0;
  int last_frame_cyc = 0;
  int t_last, n0;

  seg7_scan_decoder #(
    .SYNC_STAGES    (SYNC),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SEG_IN     (SEG_IN),
    .AN_IN      (AN_IN),
    .DIGITS     (DIGITS),
    .VALID      (VALID),
    .ERR        (ERR),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    AN_IN = 4'hF;
    SEG_IN = 7'h7F;
    tick(3);
    RST = 1'b0;
  endtask

  // Drive one digit slot; the first gcyc cycles show the previous digit's segments
  task automatic scan(input int idx, input logic [6:0] pat, input logic [6:0] ghost,
                      input int gcyc, input int dwell);
    logic [3:0] an;
    an = 4'hF;
    an[idx] = 1'b0;
    AN_IN = an;
    if (gcyc > 0) begin
      SEG_IN = ghost;
      tick(gcyc);
    end
    SEG_IN = pat;
    tick(dwell - gcyc);
  endtask

  // Frame monitor: every pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) begin
      nframes++;
      last_frame_cyc = cyc;
      chk("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        f = sb.pop_front();
        chk("digits", 32'(DIGITS), 32'(f.d));
        chk("valid", 32'(VALID), 32'(f.v));
        chk("err", 32'(ERR), 32'(f.e));
      end
    end
  end

  initial begin
    RST = 1'b1;
    AN_IN = 4'hF;
    SEG_IN = 7'h7F;
    do_reset();
    @(negedge CLK);
    chk("rst_digits", 32'(DIGITS), 32'h0);
    chk("rst_valid", 32'(VALID), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_done", 32'(FRAME_DONE), 32'h0);

    // Static single digit: only the timeout can publish it
    do_reset();
    n0 = nframes;
    sb.push_back('{16'h0005, 4'b0001, 4'b0000});
    AN_IN = 4'b1110;
    SEG_IN = pats[5];
    tick(TMO + 50);
    chk("static_frames", 32'(nframes - n0), 32'd1);

    // Full scan 4,3,2,1 and pin-to-FRAME_DONE latency of the last digit
    do_reset();
    n0 = nframes;
    sb.push_back('{16'h1234, 4'b1111, 4'b0000});
    scan(0, pats[4], 7'h7F, 0, DWELL);
    scan(1, pats[3], 7'h7F, 0, DWELL);
    scan(2, pats[2], 7'h7F, 0, DWELL);
    t_last = cyc;
    scan(3, pats[1], 7'h7F, 0, DWELL);
    chk("scan_frames", 32'(nframes - n0), 32'd1);
    chk("scan_latency", 32'(last_frame_cyc - t_last), 32'(SYNC + SETTLE + 1));

    // Ghosting: previous digit's segments linger 3 cycles after each AN switch
    do_reset();
    n0 = nframes;
    sb.push_back('{16'h0689, 4'b1111, 4'b0000});
    scan(0, pats[9], pats[0], 3, DWELL);
    scan(1, pats[8], pats[9], 3, DWELL);
    scan(2, pats[6], pats[8], 3, DWELL);
    scan(3, pats[0], pats[6], 3, DWELL);
    chk("ghost_frames", 32'(nframes - n0), 32'd1);

    // Illegal and blank digits
    do_reset();
    n0 = nframes;
    sb.push_back('{16'h0077, 4'b0011, 4'b0100});
    scan(0, pats[7], 7'h7F, 0, DWELL);
    scan(1, pats[7], 7'h7F, 0, DWELL);
    scan(2, 7'b0101010, 7'h7F, 0, DWELL);
    scan(3, 7'b1111111, 7'h7F, 0, DWELL);
    chk("illegal_frames", 32'(nframes - n0), 32'd1);

    // Reset mid-frame: two digits captured, then discarded
    n0 = nframes;
    scan(0, pats[5], 7'h7F, 0, DWELL);
    scan(1, pats[6], 7'h7F, 0, DWELL);
    AN_IN = 4'hF;
    SEG_IN = 7'h7F;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_digits", 32'(DIGITS), 32'h0);
    chk("midrst_valid", 32'(VALID), 32'h0);
    chk("midrst_err", 32'(ERR), 32'h0);
    #1;
    sb.push_back('{16'h9800, 4'b1100, 4'b0000});
    scan(2, pats[8], 7'h7F, 0, DWELL);
    scan(3, pats[9], 7'h7F, 0, DWELL);
    AN_IN = 4'hF;
    SEG_IN = 7'h7F;
    tick(TMO);
    chk("midrst_frames", 32'(nframes - n0), 32'd1);

    // Bad AN: two enables, then none; nothing may be captured or published
    do_reset();
    n0 = nframes;
    AN_IN = 4'b1100;
    SEG_IN = pats[3];
    tick(100);
    AN_IN = 4'b1111;
    tick(100);
    chk("badan_frames_short", 32'(nframes - n0), 32'd0);
    tick(TMO + 50);
    chk("badan_frames_tmo", 32'(nframes - n0), 32'd0);
    chk("badan_valid", 32'(VALID), 32'h0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
